seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter DWELL_CYCLES, default 50000: clock cycles one digit is lit per visit; legal range >= 1.
REQ-002 Parameter BLANK_CYCLES, default 4: all-dark cycles after each digit, for anti-ghosting; legal range >= 1.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  producer offers in_value this cycle.
REQ-006 in_value  input  4  unsigned value 0-15 to display.
REQ-007 in_ready  output  1  block can accept a value; a transfer occurs when in_valid && in_ready at a rising edge.
REQ-008 seg_out  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-009 an_out  output  2  digit enables, active-low: bit0 is the ones digit, bit1 is the tens digit.
REQ-010 frame_tick  output  1  one-cycle pulse when a pending value is committed to the display.

Function
REQ-011 The FSM SHALL have states SHOW_LO, BLANK_LO, SHOW_HI and BLANK_HI, and SHALL cycle SHOW_LO->BLANK_LO->SHOW_HI->BLANK_HI->SHOW_LO.
REQ-012 Each SHOW state SHALL last exactly DWELL_CYCLES cycles and each BLANK state exactly BLANK_CYCLES cycles; one frame SHALL be 2*(DWELL_CYCLES+BLANK_CYCLES) cycles.
REQ-013 The dwell counter SHALL be sized to hold max(DWELL_CYCLES,BLANK_CYCLES)-1, SHALL count 0..N-1 and SHALL clear on every state change.
REQ-014 All outputs SHALL be registered and SHALL reflect the current state with no combinational path from any input.
REQ-015 Outputs in SHOW_LO SHALL be an_out=2'b10 and seg_out=pattern(disp mod 10).
REQ-016 Outputs in SHOW_HI SHALL be an_out=2'b01 and seg_out=pattern(disp/10): pattern(0) for disp 0-9, pattern(1) for disp 10-15.
REQ-017 Outputs in either BLANK state SHALL be an_out=2'b11 and seg_out=7'b111_1111.
REQ-018 pattern(0..9) SHALL be 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-019 The block SHALL hold a 4-bit pending register and a pend flag; in_ready SHALL equal !pend.
REQ-020 On a transfer, pending SHALL load in_value and pend SHALL set; in_ready SHALL be low from the next cycle.
REQ-021 The commit SHALL occur only on the BLANK_HI->SHOW_LO transition (frame boundary) when pend=1: disp<=pending, pend clears, and frame_tick pulses high on that same edge's output cycle.
REQ-022 No mid-frame tearing is allowed: disp SHALL never change other than at a commit.
REQ-023 If a transfer occurs on the boundary edge while pend=0, the value SHALL enter pending and commit at the next boundary; frame_tick SHALL stay low for that boundary.
REQ-024 in_valid while in_ready=0 SHALL be ignored; the producer SHALL hold in_valid and in_value until accepted.
REQ-025 in_value and in_valid SHALL be ignored while rst is high.

Reset
REQ-026 On rst assertion the block SHALL immediately set state=BLANK_HI, counter=0, disp=0, pending=0, pend=0, seg_out=7'b111_1111, an_out=2'b11, in_ready=1 and frame_tick=0.
REQ-027 After rst deasserts, SHOW_LO SHALL start BLANK_CYCLES cycles later and display 0; frame_tick SHALL not pulse at that boundary.
REQ-028 A reset mid-frame or with pend=1 SHALL discard the pending value.

Configuration
REQ-029 Macro LEADING_ZERO_BLANK_EN, when defined, SHALL make SHOW_HI drive seg_out=7'b111_1111 and an_out=2'b11 whenever disp<10.
REQ-030 Without LEADING_ZERO_BLANK_EN, SHOW_HI SHALL always show pattern(0) or pattern(1) per REQ-016; timing SHALL be identical in both builds.

Verification (DWELL_CYCLES=3, BLANK_CYCLES=1)
REQ-031 Reset release -> 1 blank cycle, then 3 cycles an=10 seg=1000000, 1 blank, 3 cycles an=01 seg=1000000; frame = 8 cycles.
REQ-032 Transfer value 13 mid-SHOW_LO -> in_ready low next cycle; the current frame still shows 0; the next frame shows ones=0110000 and tens=1111001; frame_tick pulses once and in_ready returns high.
REQ-033 Transfer 7, then hold in_valid with value 9 while in_ready=0 -> 9 is not accepted until after the commit of 7; then 7 shows for one full frame and 9 commits at the following boundary.
REQ-034 Transfer 5 on the exact BLANK_HI->SHOW_LO edge with pend=0 -> the current frame keeps the old value; 5 (seg 0010010) appears one frame later.
REQ-035 With pend=1 (value 12), assert rst during SHOW_HI -> outputs blank and in_ready=1 at once; after release the display shows 0 and 12 never appears.
REQ-036 Build with LEADING_ZERO_BLANK_EN and commit 4 -> SHOW_HI cycles drive an=11 seg=1111111; commit 10 -> SHOW_HI drives an=01 seg=1111001.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Two-digit multiplexed seven-segment scanner with a one-deep tear-free input buffer.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens digit when the value is below 10.
module seven_seg_scan_ctrl #(
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] in_value,
   output logic       in_ready,
   output logic [6:0] seg_out,
   output logic [1:0] an_out,
   output logic       frame_tick
);

   localparam int MAX_CNT = ((DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES) - 1;
   localparam int CNT_W   = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [8:0]       DARK       = 9'b11_1111111;

   typedef enum logic [1:0] {SHOW_LO, BLANK_LO, SHOW_HI, BLANK_HI} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       disp;
   logic [3:0]       pending;
   logic             pend;

   function automatic logic [6:0] pattern(input logic [3:0] d);
      case (d)
         4'd0:    pattern = 7'b1000000;
         4'd1:    pattern = 7'b1111001;
         4'd2:    pattern = 7'b0100100;
         4'd3:    pattern = 7'b0110000;
         4'd4:    pattern = 7'b0011001;
         4'd5:    pattern = 7'b0010010;
         4'd6:    pattern = 7'b0000010;
         4'd7:    pattern = 7'b1111000;
         4'd8:    pattern = 7'b0000000;
         4'd9:    pattern = 7'b0010000;
         default: pattern = 7'b1111111;
      endcase
   endfunction

   function automatic logic [8:0] lo_drive(input logic [3:0] d);
      logic [3:0] ones;
      ones = (d >= 4'd10) ? (d - 4'd10) : d;
      lo_drive = {2'b10, pattern(ones)};
   endfunction

   function automatic logic [8:0] hi_drive(input logic [3:0] d);
`ifdef LEADING_ZERO_BLANK_EN
      if (d < 4'd10)
         hi_drive = DARK;
      else
         hi_drive = {2'b01, pattern(4'd1)};
`else
      hi_drive = {2'b01, pattern((d >= 4'd10) ? 4'd1 : 4'd0)};
`endif
   endfunction

   assign in_ready = ~pend;

   // Outputs are loaded on the same edge as the state they describe, so they
   // always match the registered state without any input-to-output path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= BLANK_HI;
         cnt               <= '0;
         disp              <= '0;
         pending           <= '0;
         pend              <= 1'b0;
         {an_out, seg_out} <= DARK;
         frame_tick        <= 1'b0;
      end else begin
         frame_tick <= 1'b0;
         cnt        <= cnt + CNT_W'(1);
         if (in_valid && !pend) begin
            pending <= in_value;
            pend    <= 1'b1;
         end
         case (state)
            SHOW_LO: if (cnt == DWELL_LAST) begin
               state             <= BLANK_LO;
               cnt               <= '0;
               {an_out, seg_out} <= DARK;
            end
            BLANK_LO: if (cnt == BLANK_LAST) begin
               state             <= SHOW_HI;
               cnt               <= '0;
               {an_out, seg_out} <= hi_drive(disp);
            end
            SHOW_HI: if (cnt == DWELL_LAST) begin
               state             <= BLANK_HI;
               cnt               <= '0;
               {an_out, seg_out} <= DARK;
            end
            default: if (cnt == BLANK_LAST) begin
               // Frame boundary: the only place the displayed value may change.
               state <= SHOW_LO;
               cnt   <= '0;
               if (pend) begin
                  disp              <= pending;
                  pend              <= 1'b0;
                  frame_tick        <= 1'b1;
                  {an_out, seg_out} <= lo_drive(pending);
               end else begin
                  {an_out, seg_out} <= lo_drive(disp);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed scenarios plus random producer traffic vs a frame-position model.
module tb_seven_seg_scan_ctrl;

   localparam int D = 3;
   localparam int B = 1;
   localparam int F = 2 * (D + B);
   localparam logic [8:0] DARK = 9'b11_1111111;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_value;
   logic       in_ready;
   logic [6:0] seg_out;
   logic [1:0] an_out;
   logic       frame_tick;

   seven_seg_scan_ctrl #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
      .in_ready(in_ready), .seg_out(seg_out), .an_out(an_out), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   int checks = 0;
   int errors = 0;

   // Model: position within the frame plus the buffered/displayed values.
   int         pos;
   logic [3:0] m_disp, m_pending;
   bit         m_pend, m_tick;

   function automatic logic [8:0] exp_drive(int p, logic [3:0] d);
      if (p < D) return {2'b10, pat[d % 10]};
      if (p < D + B) return DARK;
      if (p < 2 * D + B) begin
`ifdef LEADING_ZERO_BLANK_EN
         if (d < 10) return DARK;
`endif
         return {2'b01, pat[d / 10]};
      end
      return DARK;
   endfunction

   task automatic chk(string tag, logic [8:0] obs, logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("an_seg", {an_out, seg_out}, exp_drive(pos, m_disp));
      chk("in_ready", {8'b0, in_ready}, {8'b0, !m_pend});
      chk("frame_tick", {8'b0, frame_tick}, {8'b0, m_tick});
   endtask

   task automatic model_reset();
      pos = 2 * D + B;
      m_disp = 0; m_pending = 0; m_pend = 0; m_tick = 0;
   endtask

   task automatic model_edge(bit v, logic [3:0] val);
      bit old_pend;
      old_pend = m_pend;
      pos = (pos + 1) % F;
      m_tick = 0;
      if (pos == 0 && old_pend) begin
         m_disp = m_pending; m_pend = 0; m_tick = 1;
      end
      if (v && !old_pend) begin
         m_pending = val; m_pend = 1;
      end
   endtask

   // Called at a negedge; drives inputs, takes one clock, checks at the next negedge.
   task automatic cyc(bit v, logic [3:0] val);
      in_valid = v; in_value = val;
      @(posedge clk);
      #1 model_edge(v, val);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 4'd0);
   endtask

   initial begin
      bit         acc, holding;
      logic [3:0] hv;

      // Reset with a stray valid that must be ignored.
      rst = 1'b1; in_valid = 1'b1; in_value = 4'd9;
      #1 model_reset();
      check_all();
      @(negedge clk); check_all();
      @(negedge clk); check_all();
      rst = 1'b0; in_valid = 1'b0;
      idle(2 * F);

      // Value 13 offered mid-SHOW_LO.
      for (int i = 0; i < 2 * F && pos != 1; i++) cyc(1'b0, 4'd0);
      cyc(1'b1, 4'd13);
      idle(2 * F);

      // 7 accepted, 9 held until the buffer frees.
      cyc(1'b1, 4'd7);
      acc = 1'b0;
      for (int i = 0; i < 4 * F && !acc; i++) begin
         acc = !m_pend;
         cyc(1'b1, 4'd9);
      end
      chk("accept9", {8'b0, acc}, 9'd1);
      in_valid = 1'b0;
      idle(3 * F);

      // Transfer exactly on the frame-boundary edge with the buffer empty.
      for (int i = 0; i < 3 * F && !(pos == F - 1 && !m_pend); i++) cyc(1'b0, 4'd0);
      chk("boundary_setup", {8'b0, (pos == F - 1 && !m_pend)}, 9'd1);
      cyc(1'b1, 4'd5);
      idle(2 * F + 2);

      // Reset during SHOW_HI with 12 pending.
      for (int i = 0; i < 3 * F && m_pend; i++) cyc(1'b0, 4'd0);
      cyc(1'b1, 4'd12);
      for (int i = 0; i < 2 * F && pos != D + B + 1; i++) cyc(1'b0, 4'd0);
      rst = 1'b1; in_valid = 1'b1; in_value = 4'd3;
      #1 model_reset();
      check_all();
      @(negedge clk); check_all();
      rst = 1'b0; in_valid = 1'b0;
      idle(2 * F);

      // Random producer that holds its offer until accepted.
      holding = 1'b0; hv = 4'd0;
      repeat (400) begin
         if (!holding && ($urandom % 3 == 0)) begin
            holding = 1'b1;
            hv = 4'($urandom % 16);
         end
         acc = holding && !m_pend;
         cyc(holding, hv);
         if (acc) holding = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
